tx_serializer: RTL and testbench
================================

TX_SERIALIZER -- requirements
Module: tx_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL have parameter BAUD_DIV, default 4, Clk cycles per serial bit (legal values >= 1).
REQ-003 SHALL have parameter PARITY_EN, default 1; 1 = even parity bit sent, 0 = no parity bit.
REQ-004 Clk  input  1  clock; all state updates on the rising edge.
REQ-005 Reset  input  1  reset, asynchronous, active-high.
REQ-006 TxData  input  1  transmit request, level, from the memory R/W controller; held high until TxDone is seen.
REQ-007 DataIn  input  DATA_W  word to transmit; sampled only at frame load.
REQ-008 SerOut  output  1  serial line, registered; idle level 1.
REQ-009 TxDone  output  1  frame complete, registered; feeds the controller TxDone input.
REQ-010 TxBusy  output  1  high while a frame is in progress (START through STOP states).

Function
REQ-011 SHALL implement the states IDLE, START, DATA, PARITY, STOP and DONE.
REQ-012 In IDLE, a clock edge with TxData=1 SHALL latch DataIn into the shift register, clear the baud and bit counters, and enter START; TxData is level-sensitive in IDLE.
REQ-013 SerOut SHALL be 1 in IDLE and DONE, 0 in START, the shift-register LSB in DATA, the latched parity in PARITY, and 1 in STOP.
REQ-014 Each of START, each DATA bit, PARITY and STOP SHALL last exactly BAUD_DIV Clk cycles, timed by a baud counter that counts 0..BAUD_DIV-1 and wraps to 0.
REQ-015 DATA SHALL send DATA_W bits LSB first; the shift register shifts right by one at each bit boundary; a bit index counter 0..DATA_W-1 selects the exit to PARITY (PARITY_EN=1) or STOP (PARITY_EN=0).
REQ-016 The parity bit SHALL be the XOR of all latched data bits (even parity) and SHALL be computed at load.
REQ-017 SerOut SHALL go low on the same edge that takes the block from IDLE to START; frame length SHALL be (DATA_W+2+PARITY_EN)*BAUD_DIV cycles.
REQ-018 At the end of STOP, the block SHALL enter DONE and assert TxDone on that edge, i.e. (DATA_W+2+PARITY_EN)*BAUD_DIV cycles after the load edge.
REQ-019 In DONE, TxDone SHALL stay 1 while TxData=1; an edge with TxData=0 SHALL return the block to IDLE with TxDone=0, so TxDone is high for at least one cycle.
REQ-020 TxData deasserted mid-frame SHALL be ignored; the frame SHALL complete and DONE SHALL then last one cycle.
REQ-021 DataIn changes after the load edge SHALL NOT affect the frame in progress.
REQ-022 TxData held high in IDLE right after DONE exit SHALL start a new frame; back-to-back frames are legal.
REQ-023 TxBusy SHALL be 1 exactly in START, DATA, PARITY and STOP.

Reset
REQ-024 Reset=1 SHALL force, asynchronously, the state to IDLE, SerOut=1, TxDone=0, TxBusy=0, and the shift register, parity and both counters to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no TxDone; after release the block SHALL wait in IDLE for TxData.

Verification
REQ-026 Defaults, DataIn=0xA5, TxData raised -> SerOut holds 0,1,0,1,0,0,1,0,1,0,1 for 4 cycles each; TxDone=1 exactly 44 cycles after load; TxBusy=1 for those 44 cycles.
REQ-027 DataIn=0x07, PARITY_EN=1 -> parity bit=1; with PARITY_EN=0 -> no parity slot, TxDone at cycle 40.
REQ-028 TxData held high for 10 cycles after TxDone -> TxDone stays 1; TxData dropped -> TxDone=0 and SerOut=1 next edge; TxData raised again -> new START.
REQ-029 Reset pulsed at cycle 20 of a frame -> SerOut=1, TxBusy=0, TxDone=0 immediately (async); no TxDone follows.
REQ-030 DataIn changed and TxData dropped mid-frame -> original word sent in full; TxDone high for exactly one cycle.
REQ-031 BAUD_DIV=1, DataIn=0xFF -> 11 one-cycle bits 0,1,1,1,1,1,1,1,1,0,1; TxDone at cycle 11.

Source files
------------

// File: rtl/tx_serializer.sv
// Serializes one DATA_W-bit word per request as START, DATA (LSB first), optional even
// parity and STOP. TxDone is held until the requester drops TxData.
module tx_serializer #(
  parameter int DATA_W    = 8,
  parameter int BAUD_DIV  = 4,
  parameter int PARITY_EN = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              TxData,
  input  logic [DATA_W-1:0] DataIn,
  output logic              SerOut,
  output logic              TxDone,
  output logic              TxBusy
);

  localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   shift_reg, shift_nxt;
  logic                parity_bit, parity_nxt;
  logic [BAUD_W-1:0]   baud_cnt, baud_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_nxt;
  logic                ser_nxt, done_nxt, busy_nxt;
  logic                baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);

  // Outputs are registered from the next-state values, so SerOut drops on the
  // very edge that loads the frame and TxDone rises on the edge that ends STOP.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_nxt  = state;
    shift_nxt  = shift_reg;
    parity_nxt = parity_bit;
    baud_nxt   = baud_cnt;
    bit_nxt    = bit_cnt;

    unique case (state)
      IDLE: begin
        if (TxData) begin
          state_nxt  = START;
          shift_nxt  = DataIn;
          parity_nxt = ^DataIn;
          baud_nxt   = '0;
          bit_nxt    = '0;
        end
      end
      START: begin
        if (baud_end) begin
          baud_nxt  = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_nxt  = '0;
          shift_nxt = shift_reg >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_nxt   = '0;
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      PARITY: begin
        if (baud_end) begin
          baud_nxt  = '0;
          state_nxt = STOP;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_nxt  = '0;
          state_nxt = DONE;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      DONE: begin
        if (!TxData) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    ser_nxt = 1'b1;
    case (state_nxt)
      START:   ser_nxt = 1'b0;
      DATA:    ser_nxt = shift_nxt[0];
      PARITY:  ser_nxt = parity_nxt;
      default: ser_nxt = 1'b1;
    endcase
    done_nxt = (state_nxt == DONE);
    busy_nxt = (state_nxt inside {START, DATA, PARITY, STOP});
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      SerOut     <= 1'b1;
      TxDone     <= 1'b0;
      TxBusy     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      parity_bit <= parity_nxt;
      baud_cnt   <= baud_nxt;
      bit_cnt    <= bit_nxt;
      SerOut     <= ser_nxt;
      TxDone     <= done_nxt;
      TxBusy     <= busy_nxt;
    end
  end

  // Registered flags must always agree with the state they were decoded from.
  a_busy_matches_state: assert property (@(posedge Clk) disable iff (Reset)
    TxBusy == (state inside {START, DATA, PARITY, STOP}));
  a_done_matches_state: assert property (@(posedge Clk) disable iff (Reset)
    TxDone == (state == DONE));
  a_baud_in_range: assert property (@(posedge Clk) disable iff (Reset)
    baud_cnt <= BAUD_LAST);

endmodule

// File: tb/tb_tx_serializer.sv
// Scoreboard bench for tx_serializer: three parameter sets, hand-computed frame slots,
// a monitor that checks every cycle of each frame as the DUT presents it.
module tb_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       txdata;
  logic [7:0] datain;
  int         sel;

  logic tx_def, tx_np, tx_b1;
  logic ser_def, done_def, busy_def;
  logic ser_np, done_np, busy_np;
  logic ser_b1, done_b1, busy_b1;
  logic ser_s, done_s, busy_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] slots;
    int          nslots;
    int          baud;
    int          chk;
    bit          exp_done;
  } frame_t;

  frame_t exp_q[$];

  always #5 clk = ~clk;

  assign tx_def = txdata && (sel == 0);
  assign tx_np  = txdata && (sel == 1);
  assign tx_b1  = txdata && (sel == 2);

  always_comb begin
    ser_s  = ser_def;
    done_s = done_def;
    busy_s = busy_def;
    case (sel)
      1: begin ser_s = ser_np; done_s = done_np; busy_s = busy_np; end
      2: begin ser_s = ser_b1; done_s = done_b1; busy_s = busy_b1; end
      default: ;
    endcase
  end

  tx_serializer #(.DATA_W(8), .BAUD_DIV(4), .PARITY_EN(1)) u_def (
    .Clk(clk), .Reset(rst), .TxData(tx_def), .DataIn(datain),
    .SerOut(ser_def), .TxDone(done_def), .TxBusy(busy_def));

  tx_serializer #(.DATA_W(8), .BAUD_DIV(4), .PARITY_EN(0)) u_np (
    .Clk(clk), .Reset(rst), .TxData(tx_np), .DataIn(datain),
    .SerOut(ser_np), .TxDone(done_np), .TxBusy(busy_np));

  tx_serializer #(.DATA_W(8), .BAUD_DIV(1), .PARITY_EN(1)) u_b1 (
    .Clk(clk), .Reset(rst), .TxData(tx_b1), .DataIn(datain),
    .SerOut(ser_b1), .TxDone(done_b1), .TxBusy(busy_b1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slot string is written in line order: character 0 is the first slot on the wire.
  function automatic logic [15:0] to_slots(input string s);
    logic [15:0] r = '0;
    for (int i = 0; i < s.len(); i++) r[i] = (s.getc(i) == "1");
    return r;
  endfunction

  task automatic push_frame(input string s, input int baud, input int chk, input bit exp_done);
    frame_t f;
    f.slots    = to_slots(s);
    f.nslots   = s.len();
    f.baud     = baud;
    f.chk      = chk;
    f.exp_done = exp_done;
    exp_q.push_back(f);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (done_s === 1'b1) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Called at a negedge; load happens at the following posedge.
  task automatic run_frame(input int s, input logic [7:0] d, input string slots, input int baud);
    sel = s;
    push_frame(slots, baud, slots.len() * baud, 1'b1);
    datain = d;
    txdata = 1'b1;
    wait_done($sformatf("done_seen_%0h", d));
    txdata = 1'b0;
    @(negedge clk);
    check($sformatf("done_clear_%0h", d), 32'(done_s), 32'd0);
    check($sformatf("idle_ser_%0h", d), 32'(ser_s), 32'd1);
    check($sformatf("idle_busy_%0h", d), 32'(busy_s), 32'd0);
  endtask

  // Monitor: each time the selected DUT starts a frame, pop the expectation and
  // compare every cycle of it, then the TxDone cycle.
  initial begin
    frame_t f;
    forever begin
      @(negedge clk);
      if (busy_s === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          for (int k = 0; k < 400 && busy_s === 1'b1; k++) @(negedge clk);
        end else begin
          f = exp_q.pop_front();
          for (int c = 0; c < f.chk; c++) begin
            if (c > 0) @(negedge clk);
            check($sformatf("ser_s%0d_c%0d", sel, c), 32'(ser_s), 32'(f.slots[c / f.baud]));
            check($sformatf("busy_s%0d_c%0d", sel, c), 32'(busy_s), 32'd1);
            check($sformatf("done_s%0d_c%0d", sel, c), 32'(done_s), 32'd0);
          end
          if (f.exp_done) begin
            @(negedge clk);
            check($sformatf("done_at_end_s%0d", sel), 32'(done_s), 32'd1);
            check($sformatf("busy_at_end_s%0d", sel), 32'(busy_s), 32'd0);
            check($sformatf("ser_at_end_s%0d", sel), 32'(ser_s), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    rst    = 1'b0;
    txdata = 1'b0;
    datain = '0;
    sel    = 0;
    #1 rst = 1'b1;
    #2;
    check("rst_ser_def",  32'(ser_def),  32'd1);
    check("rst_done_def", 32'(done_def), 32'd0);
    check("rst_busy_def", 32'(busy_def), 32'd0);
    check("rst_ser_np",   32'(ser_np),   32'd1);
    check("rst_busy_np",  32'(busy_np),  32'd0);
    check("rst_ser_b1",   32'(ser_b1),   32'd1);
    check("rst_done_b1",  32'(done_b1),  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_wait_busy", 32'(busy_s), 32'd0);

    // Default parameters, several words
    run_frame(0, 8'hA5, "01010010101", 4);
    run_frame(0, 8'h3C, "00011110001", 4);
    run_frame(0, 8'h00, "00000000001", 4);

    // TxDone held while TxData stays high, then a new frame right after DONE exit
    sel = 0;
    push_frame("01110000011", 4, 44, 1'b1);
    datain = 8'h07;
    txdata = 1'b1;
    wait_done("done_seen_hold");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold_done_%0d", i), 32'(done_s), 32'd1);
      check($sformatf("hold_ser_%0d", i), 32'(ser_s), 32'd1);
    end
    txdata = 1'b0;
    @(negedge clk);
    check("hold_release_done", 32'(done_s), 32'd0);
    check("hold_release_ser", 32'(ser_s), 32'd1);
    run_frame(0, 8'h80, "00000000111", 4);

    // DataIn changed and TxData dropped mid-frame: original word, one-cycle TxDone
    push_frame("00011110001", 4, 44, 1'b1);
    datain = 8'h3C;
    txdata = 1'b1;
    repeat (10) @(negedge clk);
    datain = 8'hFF;
    txdata = 1'b0;
    wait_done("done_seen_midframe");
    @(negedge clk);
    check("done_one_cycle", 32'(done_s), 32'd0);

    // No parity slot: 40-cycle frame
    run_frame(1, 8'h07, "0111000001", 4);

    // One cycle per bit
    run_frame(2, 8'hFF, "01111111101", 1);
    run_frame(2, 8'h5A, "00101101001", 1);

    // Reset during cycle 20 of a frame
    sel = 0;
    push_frame("01010010101", 4, 20, 1'b0);
    datain = 8'hA5;
    txdata = 1'b1;
    @(posedge clk);
    #1 txdata = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_ser", 32'(ser_def), 32'd1);
    check("abort_busy", 32'(busy_def), 32'd0);
    check("abort_done", 32'(done_def), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done_s !== 1'b0 || busy_s !== 1'b0) saw = 1'b1;
    end
    check("no_done_after_reset", 32'(saw), 32'd0);

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
